// File: rtl/resize_sequencer.sv
// resize_sequencer: sequences one image-resize job through an external filter.
// It clears the filter, streams width*depth source pixels into it, waits for the
// filter to finish, then forwards fw*fh output pixels and pulses done.
module resize_sequencer #(
  parameter int unsigned MAX_SCALE      = 10,
  parameter int unsigned MAX_IMG_WIDTH  = 500,
  parameter int unsigned MAX_IMG_HEIGHT = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_width,
  input  logic [31:0] cfg_depth,
  input  logic [31:0] cfg_resize_size,
  input  logic        cfg_enlargen,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        flt_enable,
  output logic        flt_enable_process,
  output logic [7:0]  flt_image_input,
  input  logic        flt_finish,
  input  logic [7:0]  flt_image_output,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned CW = 32;
  localparam int unsigned PW = 8;
  localparam int unsigned EW = 2;

  localparam logic [EW-1:0] ERR_NONE  = 2'b00;
  localparam logic [EW-1:0] ERR_CFG   = 2'b01;
  localparam logic [EW-1:0] ERR_UNDER = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_PROC_WAIT,
    S_PROCESS,
    S_OUTPUT,
    S_FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] width_q, width_nxt;
  logic [CW-1:0] depth_q, depth_nxt;
  logic [CW-1:0] resize_q, resize_nxt;
  logic          enlargen_q, enlargen_nxt;
  logic [CW-1:0] load_cnt, load_cnt_nxt;
  logic [CW-1:0] out_cnt, out_cnt_nxt;
  logic [CW-1:0] load_total, load_total_nxt;
  logic [CW-1:0] out_total, out_total_nxt;
  logic          err_nxt;
  logic [EW-1:0] err_code_nxt;

  logic          cfg_bad_c;
  logic [CW-1:0] fw_c, fh_c;

  // Job configuration legality, evaluated on the live cfg inputs at start.
  always_comb begin
    cfg_bad_c = (cfg_resize_size == '0) || (cfg_resize_size > CW'(MAX_SCALE)) ||
                (cfg_width == '0)       || (cfg_width > CW'(MAX_IMG_WIDTH))    ||
                (cfg_depth == '0)       || (cfg_depth > CW'(MAX_IMG_HEIGHT))   ||
                (!cfg_enlargen && ((cfg_width < cfg_resize_size) ||
                                   (cfg_depth < cfg_resize_size)));
  end

  // Output frame dimensions from the latched job configuration.
  always_comb begin
    if (enlargen_q) begin
      fw_c = CW'(width_q * resize_q);
      fh_c = CW'(depth_q * resize_q);
    end else if (resize_q != '0) begin
      fw_c = CW'(width_q / resize_q);
      fh_c = CW'(depth_q / resize_q);
    end else begin
      fw_c = '0;
      fh_c = '0;
    end
  end

  // State, job configuration, counters and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      width_q    <= '0;
      depth_q    <= '0;
      resize_q   <= '0;
      enlargen_q <= 1'b0;
      load_cnt   <= '0;
      out_cnt    <= '0;
      load_total <= '0;
      out_total  <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      width_q    <= width_nxt;
      depth_q    <= depth_nxt;
      resize_q   <= resize_nxt;
      enlargen_q <= enlargen_nxt;
      load_cnt   <= load_cnt_nxt;
      out_cnt    <= out_cnt_nxt;
      load_total <= load_total_nxt;
      out_total  <= out_total_nxt;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
    end
  end

  // Next-state logic and state-decoded outputs; abort overrides all events.
  always_comb begin
    state_nxt          = state;
    width_nxt          = width_q;
    depth_nxt          = depth_q;
    resize_nxt         = resize_q;
    enlargen_nxt       = enlargen_q;
    load_cnt_nxt       = load_cnt;
    out_cnt_nxt        = out_cnt;
    load_total_nxt     = load_total;
    out_total_nxt      = out_total;
    err_nxt            = 1'b0;
    err_code_nxt       = err_code;
    in_ready           = 1'b0;
    flt_enable         = 1'b0;
    flt_enable_process = 1'b0;
    flt_image_input    = '0;
    out_valid          = 1'b0;
    out_data           = '0;
    busy               = (state != S_IDLE);
    done               = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad_c) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_CFG;
          end else begin
            err_code_nxt = ERR_NONE;
            width_nxt    = cfg_width;
            depth_nxt    = cfg_depth;
            resize_nxt   = cfg_resize_size;
            enlargen_nxt = cfg_enlargen;
            state_nxt    = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        load_total_nxt = CW'(width_q * depth_q);
        out_total_nxt  = CW'(fw_c * fh_c);
        load_cnt_nxt   = '0;
        out_cnt_nxt    = '0;
        state_nxt      = S_LOAD;
      end
      S_LOAD: begin
        in_ready        = 1'b1;
        flt_enable      = 1'b1;
        flt_image_input = in_data;
        if (in_valid) begin
          load_cnt_nxt = load_cnt + CW'(1);
          if (load_cnt + CW'(1) == load_total) begin
            state_nxt = S_PROC_WAIT;
          end
        end else begin
          err_nxt      = 1'b1;
          err_code_nxt = ERR_UNDER;
          state_nxt    = S_IDLE;
        end
      end
      S_PROC_WAIT: begin
        flt_enable_process = 1'b1;
        state_nxt          = S_PROCESS;
      end
      S_PROCESS: begin
        flt_enable_process = 1'b1;
        if (flt_finish) begin
          state_nxt = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        flt_enable_process = 1'b1;
        out_valid          = 1'b1;
        out_data           = PW'(flt_image_output);
        out_cnt_nxt        = out_cnt + CW'(1);
        if (out_cnt + CW'(1) == out_total) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_nxt    = S_IDLE;
      err_nxt      = 1'b0;
      err_code_nxt = err_code;
    end
  end

endmodule

// File: tb/tb_resize_sequencer.sv
// Self-checking bench for resize_sequencer with a behavioural filter model
// and a scoreboard of expected output pixels.
`timescale 1ns/1ps
module tb_resize_sequencer;

  localparam int FLT_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_width = '0;
  logic [31:0] cfg_depth = '0;
  logic [31:0] cfg_resize_size = '0;
  logic        cfg_enlargen = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        flt_enable;
  logic        flt_enable_process;
  logic [7:0]  flt_image_input;
  logic        flt_finish;
  logic [7:0]  flt_image_output;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  resize_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_depth(cfg_depth),
    .cfg_resize_size(cfg_resize_size), .cfg_enlargen(cfg_enlargen),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flt_enable(flt_enable), .flt_enable_process(flt_enable_process),
    .flt_image_input(flt_image_input), .flt_finish(flt_finish),
    .flt_image_output(flt_image_output), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .done(done), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Current job geometry, used by the filter model to resize.
  int j_w = 1, j_r = 1, j_fw = 0;
  bit j_enl = 1'b0;

  // Filter model: stores loaded pixels, raises finish FLT_LAT cycles into
  // processing, then streams nearest-neighbour resized pixels.
  logic [7:0] fmem [0:1023];
  int  fcnt, pcnt, oidx;
  logic fin, streaming;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 0; pcnt <= 0; oidx <= 0; fin <= 1'b0; streaming <= 1'b0;
    end else if (!flt_enable && !flt_enable_process) begin
      fcnt <= 0; pcnt <= 0; oidx <= 0; fin <= 1'b0; streaming <= 1'b0;
    end else if (flt_enable) begin
      if (in_valid) begin
        fmem[fcnt & 1023] <= flt_image_input;
        fcnt <= fcnt + 1;
      end
    end else begin
      pcnt <= pcnt + 1;
      if (pcnt == FLT_LAT) fin <= 1'b1;
      if (fin) streaming <= 1'b1;
      if (streaming) oidx <= oidx + 1;
    end
  end

  assign flt_finish = fin;

  always_comb begin : flt_model_out
    int ox, oy, sx, sy;
    ox = 0; oy = 0;
    if (j_fw != 0) begin
      ox = oidx % j_fw;
      oy = oidx / j_fw;
    end
    if (j_enl) begin
      sx = ox / j_r;
      sy = oy / j_r;
    end else begin
      sx = ox * j_r;
      sy = oy * j_r;
    end
    flt_image_output = streaming ? fmem[(sy * j_w + sx) & 1023] : 8'hEE;
  end

  // Scoreboard and monitor, sampled on the falling edge.
  logic [7:0] exp_q [$];
  int  n_out, n_rdy;
  bit  saw_fen, saw_done, saw_err;

  always @(negedge clk) begin
    if (flt_enable) saw_fen = 1'b1;
    if (done) saw_done = 1'b1;
    if (err) saw_err = 1'b1;
    if (in_ready) n_rdy++;
    if (flt_enable || flt_enable_process)
      chk("flt_exclusive", int'(flt_enable && flt_enable_process), 0);
    if (out_valid) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_extra: got out_valid with data %0d, required no output", out_data);
      end else begin
        chk("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    int w, d, r;
    bit enl;
    bit exp_err;
    int exp_outs;
    int base, step;
  } vec_t;

  vec_t vecs [12];

  task automatic clear_mon();
    n_out = 0; n_rdy = 0; saw_fen = 1'b0; saw_done = 1'b0; saw_err = 1'b0;
  endtask

  function automatic logic [7:0] src_pix(input vec_t v, input int i);
    return 8'(v.base + i * v.step);
  endfunction

  // Push the expected resized frame for a job onto the scoreboard.
  task automatic push_exp(input vec_t v);
    int fw, fh, sx, sy;
    fw = v.enl ? v.w * v.r : v.w / v.r;
    fh = v.enl ? v.d * v.r : v.d / v.r;
    for (int oy = 0; oy < fh; oy++) begin
      for (int ox = 0; ox < fw; ox++) begin
        sx = v.enl ? ox / v.r : ox * v.r;
        sy = v.enl ? oy / v.r : oy * v.r;
        exp_q.push_back(src_pix(v, sy * v.w + sx));
      end
    end
  endtask

  // Drive cfg and a one-cycle start; returns 1 ns after the accepting edge.
  task automatic start_job(input vec_t v);
    j_w = v.w; j_r = (v.r == 0) ? 1 : v.r; j_enl = v.enl;
    j_fw = v.enl ? v.w * v.r : ((v.r == 0) ? 0 : v.w / v.r);
    cfg_width = 32'(v.w); cfg_depth = 32'(v.d);
    cfg_resize_size = 32'(v.r); cfg_enlargen = v.enl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Stream n pixels back-to-back starting in the first LOAD cycle.
  task automatic load_pixels(input vec_t v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = src_pix(v, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc;
    clear_mon();
    if (!v.exp_err) push_exp(v);
    start_job(v);
    if (v.exp_err) begin
      chk({nm, "_err"}, int'(err), 1);
      chk({nm, "_err_code"}, int'(err_code), 1);
      chk({nm, "_busy"}, int'(busy), 0);
      repeat (4) @(posedge clk);
      #1;
      chk({nm, "_err_pulse_end"}, int'(err), 0);
      chk({nm, "_err_code_hold"}, int'(err_code), 1);
      chk({nm, "_flt_enable_seen"}, int'(saw_fen), 0);
    end else begin
      chk({nm, "_busy_clear"}, int'(busy), 1);
      chk({nm, "_fen_clear"}, int'(flt_enable), 0);
      @(posedge clk); #1;
      load_pixels(v, v.w * v.d);
      chk({nm, "_proc_wait_fep"}, int'(flt_enable_process), 1);
      chk({nm, "_proc_wait_fen"}, int'(flt_enable), 0);
      cyc = 0;
      while (!done && cyc < 4000) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk({nm, "_done"}, int'(done), 1);
      chk({nm, "_out_count"}, n_out, v.exp_outs);
      chk({nm, "_scoreboard_left"}, exp_q.size(), 0);
      chk({nm, "_in_ready_cycles"}, n_rdy, v.w * v.d);
      chk({nm, "_err_seen"}, int'(saw_err), 0);
      @(posedge clk); #1;
      chk({nm, "_idle_busy"}, int'(busy), 0);
      chk({nm, "_done_pulse_end"}, int'(done), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{w: 4,   d: 4,   r: 2,  enl: 0, exp_err: 0, exp_outs: 4,  base: 0,  step: 1};
    vecs[1]  = '{w: 2,   d: 2,   r: 3,  enl: 1, exp_err: 0, exp_outs: 36, base: 10, step: 10};
    vecs[2]  = '{w: 5,   d: 3,   r: 2,  enl: 0, exp_err: 0, exp_outs: 2,  base: 3,  step: 7};
    vecs[3]  = '{w: 1,   d: 1,   r: 1,  enl: 1, exp_err: 0, exp_outs: 1,  base: 99, step: 1};
    vecs[4]  = '{w: 10,  d: 10,  r: 10, enl: 0, exp_err: 0, exp_outs: 1,  base: 5,  step: 3};
    vecs[5]  = '{w: 3,   d: 2,   r: 1,  enl: 1, exp_err: 0, exp_outs: 6,  base: 40, step: 11};
    vecs[6]  = '{w: 4,   d: 4,   r: 0,  enl: 0, exp_err: 1, exp_outs: 0,  base: 0,  step: 1};
    vecs[7]  = '{w: 20,  d: 20,  r: 11, enl: 0, exp_err: 1, exp_outs: 0,  base: 0,  step: 1};
    vecs[8]  = '{w: 501, d: 4,   r: 2,  enl: 0, exp_err: 1, exp_outs: 0,  base: 0,  step: 1};
    vecs[9]  = '{w: 1,   d: 4,   r: 2,  enl: 0, exp_err: 1, exp_outs: 0,  base: 0,  step: 1};
    vecs[10] = '{w: 4,   d: 501, r: 2,  enl: 1, exp_err: 1, exp_outs: 0,  base: 0,  step: 1};
    vecs[11] = '{w: 4,   d: 0,   r: 1,  enl: 1, exp_err: 1, exp_outs: 0,  base: 0,  step: 1};

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_flt_ctrl", int'(flt_enable | flt_enable_process), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done_err", int'(done | err), 0);
    chk("rst_err_code", int'(err_code), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Underflow: in_valid drops at pixel 5 of 16.
    clear_mon();
    start_job(vecs[0]);
    @(posedge clk); #1;
    load_pixels(vecs[0], 5);
    @(posedge clk); #1;
    chk("uf_err", int'(err), 1);
    chk("uf_err_code", int'(err_code), 2);
    chk("uf_busy", int'(busy), 0);
    chk("uf_flt_ctrl", int'(flt_enable | flt_enable_process), 0);
    @(posedge clk); #1;
    chk("uf_err_pulse_end", int'(err), 0);
    chk("uf_err_code_hold", int'(err_code), 2);
    repeat (5) @(posedge clk);
    #1;
    chk("uf_no_output", n_out, 0);
    chk("uf_in_ready_cycles", n_rdy, 6);

    // Abort after two output pixels; a start in the same cycle is ignored.
    clear_mon();
    push_exp(vecs[1]);
    start_job(vecs[1]);
    chk("ab_err_code_cleared", int'(err_code), 0);
    @(posedge clk); #1;
    load_pixels(vecs[1], 4);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ab_output_reached", int'(out_valid), 1);
    @(posedge clk); #1;
    abort = 1'b1;
    start = 1'b1;
    cfg_resize_size = 32'd0;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_flt_ctrl", int'(flt_enable | flt_enable_process), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("ab_out_count", n_out, 2);
    chk("ab_no_done", int'(saw_done), 0);
    chk("ab_no_err", int'(saw_err), 0);
    exp_q.delete();

    // Reset pulsed while in PROCESS, then a normal job.
    clear_mon();
    start_job(vecs[0]);
    @(posedge clk); #1;
    load_pixels(vecs[0], 16);
    @(posedge clk); #1;
    chk("rp_in_process", int'(flt_enable_process & busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rp_busy", int'(busy), 0);
    chk("rp_flt_ctrl", int'(flt_enable | flt_enable_process), 0);
    chk("rp_outputs", int'(in_ready | out_valid | done | err), 0);
    chk("rp_err_code", int'(err_code), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rp_no_output", n_out, 0);
    run_vec(vecs[0], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/resize_sequencer.md
RESIZE_SEQUENCER -- requirements
Module: resize_sequencer

Interface
REQ-001 Parameter MAX_SCALE, default 10; largest legal resize_size.
REQ-002 Parameter MAX_IMG_WIDTH, default 500; largest legal cfg_width.
REQ-003 Parameter MAX_IMG_HEIGHT, default 500; largest legal cfg_depth.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle job request; accepted only in IDLE.
- abort  in  1  synchronous job cancel.
- cfg_width, cfg_depth, cfg_resize_size  in  32 each  job configuration.
- cfg_enlargen  in  1  job configuration.
- in_valid  in  1  source pixel valid.
- in_data  in  8  source pixel.
- in_ready  out  1  sequencer accepting pixels.
- flt_enable, flt_enable_process  out  1 each  filter load and process controls.
- flt_image_input  out  8  pixel to filter.
- flt_finish  in  1  filter finish.
- flt_image_output  in  8  filter pixel.
- out_valid  out  1  output pixel valid (no backpressure).
- out_data  out  8  output pixel.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- err  out  1  one-cycle error pulse.
- err_code  out  2  error cause: 01 config, 10 underflow; holds until the next accepted start.

Function
REQ-006 States SHALL be IDLE, CLEAR, LOAD, PROC_WAIT, PROCESS, OUTPUT, FINISH.
REQ-007 On start in IDLE, the block SHALL latch all cfg_* inputs, clear err_code, and move to CLEAR.
- The job is rejected with err=1 and err_code=01, staying in IDLE, if any of these hold:
  - resize_size = 0 or resize_size > MAX_SCALE;
  - width = 0 or width > MAX_IMG_WIDTH;
  - depth = 0 or depth > MAX_IMG_HEIGHT;
  - enlargen = 0 and (width < resize_size or depth < resize_size).
REQ-008 CLEAR SHALL last exactly 1 cycle with both filter controls low, which wipes the filter, then go to LOAD.
REQ-009 In LOAD:
- flt_enable=1 and in_ready=1;
- flt_image_input equals in_data combinationally;
- one pixel is consumed per cycle;
- a 32-bit load counter counts to width*depth.
REQ-010 The accepted pixel count that ends LOAD SHALL be width*depth. After that pixel, the next state is PROC_WAIT with flt_enable=0 and flt_enable_process=1.
REQ-011 If in_valid=0 in any LOAD cycle, the block SHALL:
- drive both filter controls low on the next cycle;
- pulse err with err_code=10;
- return to IDLE.
REQ-012 PROC_WAIT SHALL last 1 cycle, ignoring the stale flt_finish, then go to PROCESS.
REQ-013 PROCESS SHALL hold flt_enable_process=1 and move to OUTPUT on the first cycle flt_finish=1.
REQ-014 Output pixel count SHALL be fw*fh, computed in 32 bits and fixed at job latch:
- shrink (enlargen=0): fw = width/resize_size, fh = depth/resize_size (truncating);
- enlarge (enlargen=1): fw = width*resize_size, fh = depth*resize_size.
REQ-015 In OUTPUT:
- out_valid=1 and out_data=flt_image_output every cycle;
- exactly fw*fh consecutive cycles;
- the first valid pixel is in the cycle after the one in which flt_finish was first seen high;
- then go to FINISH.
REQ-016 FINISH SHALL last 1 cycle: both filter controls low, done=1, then IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 start while busy SHALL be ignored.
REQ-019 abort in any non-IDLE state SHALL, on the next cycle, return to IDLE with both filter controls low, and SHALL NOT raise done or err. abort takes priority over the start, finish and underflow events of the same cycle.
REQ-020 flt_enable and flt_enable_process SHALL never both be 1.
REQ-021 in_ready, out_valid, done and err SHALL be 0 outside the states named in REQ-007 through REQ-016.

Reset
REQ-022 On rst_n=0 the block SHALL enter IDLE asynchronously, with all outputs and err_code 0 and all counters cleared.
REQ-023 Reset deassertion SHALL be taken synchronously. Reset mid-job SHALL drop the filter controls immediately.

Verification
REQ-024 Shrink: width=4, depth=4, resize=2, enlargen=0, pixels 0..15 streamed back-to-back -> in_ready for 16 cycles, then exactly 4 out_valid cycles, then a done pulse.
REQ-025 Enlarge: width=2, depth=2, resize=3, enlargen=1, pixels {10,20,30,40} -> 36 out_valid pixels in row-major order, each source pixel repeated 3x3, then done.
REQ-026 Config errors: start with resize=0, with resize=11, with width=501, and with width=1, resize=2, enlargen=0 -> each gives err=1, err_code=01, busy stays 0, flt_enable is never raised.
REQ-027 Underflow: in_valid dropped at pixel 5 of 16 -> err=1 with err_code=10, next cycle IDLE, both filter controls 0, no out_valid.
REQ-028 Abort and reset: abort asserted in OUTPUT after 2 pixels -> no further out_valid and no done. rst_n pulsed low in PROCESS -> all outputs 0 at once, and a following job completes normally.
